write_once_bank_ctrl: RTL

Controller for a small bank of 16-bit write-once configuration registers shared by several requesters. Performs round-robin arbitration, sequences each accepted write through a lock check, and applies write-once semantics: bit 0 of the written data becomes the register's sticky lock, and the stored value always has bit 0 cleared. It sits between bus-side requesters and the locked configuration registers consumed by downstream IP.

---
 rtl/write_once_bank_ctrl_pkg.sv | 20 ++
 rtl/write_once_bank_ctrl_rr_arbiter.sv | 35 +++
 rtl/write_once_bank_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/write_once_bank_ctrl_pkg.sv
// Shared types and constants for the write-once register bank controller.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package write_once_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Position of the sticky lock inside a written data word.
    localparam int LOCK_BIT = 0;

    // Index width for a count of n items; never below one bit.
    function automatic int calc_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/write_once_bank_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_winner, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter
    import write_once_bank_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW = calc_aw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_winner,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic          found;
    logic [IW-1:0] cand;

    // Scan from last_winner+1 around the ring; the first active request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_winner) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/write_once_bank_ctrl.sv
// Write-once config register bank: round-robin arbitration, lock check, sticky lock bit.
// Latency: gnt one cycle after req is sampled, done/err and register update one cycle later.
// Backpressure: one write in flight; other requesters hold req until their own done.
module write_once_bank_ctrl
    import write_once_bank_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16,
    parameter int AW       = calc_aw(NUM_REGS)
) (
    input  logic                       Clk,
    input  logic                       ip_reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*AW-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic [NUM_REGS*DATA_W-1:0] reg_data,
    output logic [NUM_REGS-1:0]        lock_status
);

    localparam int IW = calc_aw(NUM_REQ);

    state_t              state;
    logic [IW-1:0]       last_winner;
    logic [IW-1:0]       win_idx;
    logic [AW-1:0]       addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   bank [NUM_REGS];

    logic [AW-1:0]       addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                addr_ok;
    logic                reject;
    logic [DATA_W-1:0]   wr_val;

    // Split the flattened request buses into per-requester fields.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Present the register bank as one flattened output.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pack
        assign reg_data[r*DATA_W +: DATA_W] = bank[r];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req),
        .last_winner (last_winner),
        .grant       (arb_grant),
        .grant_idx   (arb_idx)
    );

    // Reject out-of-range addresses and already-locked registers; stored value never keeps the lock bit.
    always_comb begin
        addr_ok          = (int'(addr_q) < NUM_REGS);
        reject           = !addr_ok || lock_status[addr_q];
        wr_val           = data_q;
        wr_val[LOCK_BIT] = 1'b0;
    end

    // Transaction FSM plus register bank; reset aborts any write in flight.
    always_ff @(posedge Clk) begin
        if (ip_reset) begin
            state       <= IDLE;
            last_winner <= IW'(NUM_REQ - 1);
            win_idx     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            gnt         <= '0;
            done        <= '0;
            err         <= 1'b0;
            lock_status <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                bank[r] <= '0;
            end
        end else begin
            gnt  <= '0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        win_idx     <= arb_idx;
                        last_winner <= arb_idx;
                        addr_q      <= addr_arr[arb_idx];
                        data_q      <= data_arr[arb_idx];
                        gnt         <= arb_grant;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (!reject) begin
                        bank[addr_q]        <= wr_val;
                        lock_status[addr_q] <= data_q[LOCK_BIT];
                    end
                    done[win_idx] <= 1'b1;
                    err           <= reject;
                    state         <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
